// File: rtl/frame_centroid.sv
// Per-frame centroid of foreground pixels in a 2**W x 2**W binarized raster stream.
// Optional build macro CENTROID_SMOOTH_EN averages each new centroid with the previous one.
module frame_centroid #(
    parameter int W       = 6,
    parameter int MIN_CNT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_fg,
    input  logic         i_en,
    output logic [W-1:0] o_cx,
    output logic [W-1:0] o_cy,
    output logic         o_valid,
    output logic         o_lost,
    output logic         o_overrun
);

    localparam int SW  = 3 * W;
    localparam int CW  = 2 * W + 1;
    localparam int RW  = CW + 1;
    localparam int SCW = $clog2(SW);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t          state_reg, state_next;
    logic            fe_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   div_reg;
    logic [SCW-1:0]  step_reg;
    logic [SW-1:0]   sum_reg [2];
    logic [SW-1:0]   dq_reg  [2];
    logic [CW-1:0]   rem_reg [2];
    logic [W-1:0]    coord   [2];
    logic [W-1:0]    quot    [2];

    logic pix_fg, frame_end, cnt_ok;
    logic load_div, div_step, report_lost, report_done, drop_frame;

    assign coord[0]  = i_x;
    assign coord[1]  = i_y;
    assign pix_fg    = i_en & i_fg;
    assign frame_end = i_en & (&i_x) & (&i_y);
    // A zero count must never reach the divider, even if MIN_CNT is configured to 0.
    assign cnt_ok    = (cnt_reg >= CW'(MIN_CNT)) && (cnt_reg != '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fe_reg && cnt_ok) state_next = DIV;
            DIV:     if (step_reg == SCW'(SW - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_div    = 1'b0;
        div_step    = 1'b0;
        report_lost = 1'b0;
        report_done = 1'b0;
        drop_frame  = 1'b0;
        case (state_reg)
            IDLE: begin
                load_div    = fe_reg & cnt_ok;
                report_lost = fe_reg & ~cnt_ok;
            end
            DIV: begin
                div_step   = 1'b1;
                drop_frame = fe_reg;
            end
            DONE: begin
                report_done = 1'b1;
                drop_frame  = fe_reg;
            end
            default: ;
        endcase
    end

    // fe_reg marks the cycle after the frame-end pixel: the accumulators then hold the
    // complete frame, are handed to the divider, and restart with the current pixel.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            fe_reg   <= 1'b0;
            cnt_reg  <= '0;
            div_reg  <= '0;
            step_reg <= '0;
        end else begin
            fe_reg <= frame_end;
            if (fe_reg) begin
                cnt_reg <= CW'(pix_fg);
            end else if (pix_fg) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load_div) begin
                div_reg  <= cnt_reg;
                step_reg <= '0;
            end else if (div_step) begin
                step_reg <= step_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            logic [RW-1:0] shifted;
            logic [CW-1:0] diff;
            logic          q_bit;

            // Restoring division: dq_reg shifts the dividend out and the quotient in.
            assign shifted = {rem_reg[gi], dq_reg[gi][SW-1]};
            assign q_bit   = shifted >= {1'b0, div_reg};
            assign diff    = shifted[CW-1:0] - div_reg;
            assign quot[gi] = dq_reg[gi][W-1:0];

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    sum_reg[gi] <= '0;
                    dq_reg[gi]  <= '0;
                    rem_reg[gi] <= '0;
                end else begin
                    if (fe_reg) begin
                        sum_reg[gi] <= pix_fg ? SW'(coord[gi]) : '0;
                    end else if (pix_fg) begin
                        sum_reg[gi] <= sum_reg[gi] + SW'(coord[gi]);
                    end
                    if (load_div) begin
                        dq_reg[gi]  <= sum_reg[gi];
                        rem_reg[gi] <= '0;
                    end else if (div_step) begin
                        rem_reg[gi] <= q_bit ? diff : shifted[CW-1:0];
                        dq_reg[gi]  <= {dq_reg[gi][SW-2:0], q_bit};
                    end
                end
            end
        end
    endgenerate

`ifdef CENTROID_SMOOTH_EN
    logic [W:0] sm_x, sm_y;
    assign sm_x = {1'b0, o_cx} + {1'b0, quot[0]};
    assign sm_y = {1'b0, o_cy} + {1'b0, quot[1]};
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            o_cx      <= {1'b1, {(W-1){1'b0}}};
            o_cy      <= {1'b1, {(W-1){1'b0}}};
            o_valid   <= 1'b0;
            o_lost    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= report_done;
            o_lost  <= report_lost;
            if (drop_frame) begin
                o_overrun <= 1'b1;
            end
            if (report_done) begin
`ifdef CENTROID_SMOOTH_EN
                o_cx <= sm_x[W:1];
                o_cy <= sm_y[W:1];
`else
                o_cx <= quot[0];
                o_cy <= quot[1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_centroid.sv
// Directed and randomized frames for frame_centroid, checked against a plain-arithmetic centroid model.
module tb_frame_centroid;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] i_x = '0;
    logic [5:0] i_y = '0;
    logic       i_fg = 1'b0;
    logic       i_en = 1'b0;
    logic [5:0] o_cx, o_cy;
    logic       o_valid, o_lost, o_overrun;

    int     checks = 0;
    int     errors = 0;
    int     exp_cx = 32;
    int     exp_cy = 32;
    longint sx, sy, cnt;

    frame_centroid #(.W(6), .MIN_CNT(16)) dut (
        .CLK(CLK), .RST(RST), .i_x(i_x), .i_y(i_y), .i_fg(i_fg), .i_en(i_en),
        .o_cx(o_cx), .o_cy(o_cy), .o_valid(o_valid), .o_lost(o_lost),
        .o_overrun(o_overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one full raster frame ending with the (63,63) pixel; the model sums stay in sx/sy/cnt.
    task automatic send_frame(input bit dens, input int p, input int x0, input int x1,
                              input int y0, input int y1, input bit gaps);
        bit fg;
        sx = 0; sy = 0; cnt = 0;
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++) begin
                if (gaps) begin
                    while ($urandom_range(7) == 0) begin
                        i_en = 1'b0;
                        i_fg = 1'b1;
                        i_x  = 6'($urandom_range(63));
                        i_y  = 6'($urandom_range(63));
                        step();
                    end
                end
                if (dens) fg = ($urandom_range(99) < p);
                else      fg = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
                i_en = 1'b1;
                i_fg = fg;
                i_x  = 6'(x);
                i_y  = 6'(y);
                if (fg) begin
                    sx  += x;
                    sy  += y;
                    cnt += 1;
                end
                step();
            end
        end
        i_en = 1'b0;
        i_fg = 1'b0;
    endtask

    // Watches the 20 cycles after frame end; fe2_at>0 injects a second frame end at that cycle.
    task automatic finish_frame(input string name, input int fe2_at);
        bit lost;
        lost = (cnt < 16);
        for (int j = 1; j <= 20; j++) begin
            if (j == fe2_at) begin
                i_en = 1'b1; i_fg = 1'b1; i_x = 6'd63; i_y = 6'd63;
            end else begin
                i_en = 1'b0; i_fg = 1'b0;
            end
            step();
            check({name, "_lost"},  32'(o_lost),  32'(j == 1 && lost));
            check({name, "_valid"}, 32'(o_valid), 32'(j == 20 && !lost));
        end
        i_en = 1'b0;
        i_fg = 1'b0;
        if (!lost) begin
            exp_cx = int'(sx / cnt);
            exp_cy = int'(sy / cnt);
        end
        check({name, "_cx"}, 32'(o_cx), 32'(exp_cx));
        check({name, "_cy"}, 32'(o_cy), 32'(exp_cy));
        $display("frame %s cnt %0d sx %0d sy %0d lost %0d cx %0d cy %0d", name, cnt, sx, sy,
                 lost, o_cx, o_cy);
    endtask

    initial begin
        int x0, y0;
        RST = 1'b0;
        step();
        step();
        check("rst_cx", 32'(o_cx), 32);
        check("rst_cy", 32'(o_cy), 32);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_lost", 32'(o_lost), 0);
        check("rst_overrun", 32'(o_overrun), 0);
        RST = 1'b1;

        send_frame(1'b0, 0, 63, 63, 63, 63, 1'b0);
        finish_frame("single", 0);
        send_frame(1'b0, 0, 10, 19, 20, 29, 1'b0);
        finish_frame("block", 0);
        send_frame(1'b0, 0, 0, 63, 0, 63, 1'b0);
        finish_frame("whole", 0);

        send_frame(1'b1, 0, 0, 0, 0, 0, 1'b1);
        finish_frame("rand_empty", 0);
        send_frame(1'b1, int'($urandom_range(60, 5)), 0, 0, 0, 0, 1'b1);
        finish_frame("rand_dens_a", 0);
        send_frame(1'b1, int'($urandom_range(95, 40)), 0, 0, 0, 0, 1'b1);
        finish_frame("rand_dens_b", 0);
        x0 = int'($urandom_range(40));
        y0 = int'($urandom_range(40));
        send_frame(1'b0, 0, x0, int'($urandom_range(63, x0 + 4)), y0,
                   int'($urandom_range(63, y0 + 4)), 1'b1);
        finish_frame("rand_rect", 0);

        check("pre_overrun", 32'(o_overrun), 0);
        send_frame(1'b0, 0, 40, 49, 5, 14, 1'b0);
        finish_frame("overrun", 10);
        check("overrun_set", 32'(o_overrun), 1);

        send_frame(1'b0, 0, 0, 63, 0, 63, 1'b0);
        for (int j = 0; j < 5; j++) step();
        RST = 1'b0;
        step();
        RST = 1'b1;
        exp_cx = 32;
        exp_cy = 32;
        check("middiv_cx", 32'(o_cx), 32'(exp_cx));
        check("middiv_cy", 32'(o_cy), 32'(exp_cy));
        check("middiv_overrun", 32'(o_overrun), 0);
        for (int j = 0; j < 20; j++) begin
            step();
            check("middiv_valid", 32'(o_valid), 0);
        end
        check("middiv_hold_cx", 32'(o_cx), 32'(exp_cx));
        send_frame(1'b0, 0, 10, 19, 20, 29, 1'b0);
        finish_frame("after_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
